// File: rtl/mac_operand_feeder.sv
// Operand-side initiator for the PE MAC: streams one job of (a,b) pairs into the mac,
// dumps the accumulator and hands the captured sum downstream over valid/ready.
module mac_operand_feeder #(
   parameter int DATA_W     = 16,
   parameter int CNT_W      = 10,
   parameter int MAC_LAT    = 1,
   parameter int RESULT_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  len,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_a,
   input  logic [DATA_W-1:0] s_b,
   output logic [DATA_W-1:0] mac_a,
   output logic [DATA_W-1:0] mac_b,
   output logic              mac_out_en,
   input  logic [DATA_W-1:0] mac_result,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              busy,
   output logic              done
);

   localparam int LAT_MAX = (MAC_LAT > RESULT_LAT) ? MAC_LAT : RESULT_LAT;
   localparam int LAT_W   = $clog2(LAT_MAX + 1);
   localparam logic [LAT_W-1:0] FLUSH_LAST = LAT_W'(MAC_LAT - 1);
   localparam logic [LAT_W-1:0] WAIT_LAST  = LAT_W'(RESULT_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_FEED,
      S_FLUSH,
      S_DUMP,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [LAT_W-1:0] lat_cnt;
   logic             purge;
   logic             accept;

   assign accept = s_valid && s_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_CLEAR;
         cnt        <= '0;
         lat_cnt    <= '0;
         purge      <= 1'b0;
         s_ready    <= 1'b0;
         mac_a      <= '0;
         mac_b      <= '0;
         mac_out_en <= 1'b0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         // NOTE: non-blocking defaults here make every pulse-type output fall back to
         // its idle value unless a state below explicitly re-asserts it this cycle.
         mac_a      <= '0;
         mac_b      <= '0;
         mac_out_en <= 1'b0;
         done       <= 1'b0;

         unique case (state)
            // Dump whatever an aborted job left in the accumulator, then throw it away.
            S_CLEAR: begin
               mac_out_en <= 1'b1;
               purge      <= 1'b1;
               busy       <= 1'b1;
               state      <= S_DUMP;
            end

            S_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (len != '0) begin
                     cnt     <= len;
                     s_ready <= 1'b1;
                     state   <= S_FEED;
                  end else begin
                     mac_out_en <= 1'b1;
                     state      <= S_DUMP;
                  end
               end
            end

            S_FEED: begin
               if (accept) begin
                  mac_a <= s_a;
                  mac_b <= s_b;
                  cnt   <= cnt - CNT_ONE;
                  if (cnt == CNT_ONE) begin
                     s_ready <= 1'b0;
                     lat_cnt <= '0;
                     state   <= S_FLUSH;
                  end
               end
            end

            // The last pair is still on the mac inputs during the first flush cycle.
            S_FLUSH: begin
               if (lat_cnt == FLUSH_LAST) begin
                  mac_out_en <= 1'b1;
                  state      <= S_DUMP;
               end else begin
                  lat_cnt <= lat_cnt + LAT_W'(1);
               end
            end

            S_DUMP: begin
               lat_cnt <= '0;
               state   <= S_WAIT;
            end

            S_WAIT: begin
               if (lat_cnt == WAIT_LAST) begin
                  if (purge) begin
                     purge <= 1'b0;
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     res_data  <= mac_result;
                     res_valid <= 1'b1;
                     state     <= S_HOLD;
                  end
               end else begin
                  lat_cnt <= lat_cnt + LAT_W'(1);
               end
            end

            S_HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end

            default: begin
               s_ready   <= 1'b0;
               res_valid <= 1'b0;
               purge     <= 1'b0;
               busy      <= 1'b1;
               state     <= S_CLEAR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: behavioural mac, a sum-of-accepted-products model
// checked every cycle, and directed jobs with hand-computed results.
module tb_mac_operand_feeder;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [CNT_W-1:0]  len;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_a;
   logic [DATA_W-1:0] s_b;
   logic [DATA_W-1:0] mac_a;
   logic [DATA_W-1:0] mac_b;
   logic              mac_out_en;
   logic [DATA_W-1:0] mac_result = '0;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;
   logic              busy;
   logic              done;

   int n_checks = 0;
   int n_errors = 0;

   mac_operand_feeder #(
      .DATA_W(DATA_W), .CNT_W(CNT_W), .MAC_LAT(1), .RESULT_LAT(1)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
      .mac_a(mac_a), .mac_b(mac_b), .mac_out_en(mac_out_en), .mac_result(mac_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural mac: one product per cycle into the accumulator, dump on output_en.
   logic [DATA_W-1:0] acc = '0;
   always @(posedge clk) begin
      if (mac_out_en) begin
         mac_result <= acc;
         acc        <= mac_a * mac_b;
      end else begin
         acc <= acc + mac_a * mac_b;
      end
   end

   logic rst_q = 1'b1;
   always @(posedge clk) rst_q <= rst;

   // Model: operands appear on the mac one cycle after acceptance, zero otherwise;
   // the result of a job is the truncated sum of the products accepted for it.
   logic              pend_acc = 1'b0;
   logic [DATA_W-1:0] pend_a = '0, pend_b = '0;
   logic [DATA_W-1:0] job_sum = '0;
   logic              prev_hold = 1'b0, prev_hs = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;
   int                oen_cnt = 0;
   int                done_cnt = 0;

   always @(negedge clk) begin
      if (rst_q) begin
         check("reset_outputs",
               64'({s_ready, mac_out_en, res_valid, busy, done, mac_a, mac_b, res_data}), 64'd0);
         pend_acc  = 1'b0;
         job_sum   = '0;
         prev_hold = 1'b0;
         prev_hs   = 1'b0;
      end else begin
         if (pend_acc) begin
            check("mac_a_forward", 64'(mac_a), 64'(pend_a));
            check("mac_b_forward", 64'(mac_b), 64'(pend_b));
         end else begin
            check("mac_operands_zero", 64'({mac_a, mac_b}), 64'd0);
         end
         if (mac_out_en) begin
            oen_cnt++;
            check("out_en_while_ready", 64'(s_ready), 64'd0);
         end
         check("done_after_handshake", 64'(done), 64'(prev_hs));
         if (done) done_cnt++;
         if (res_valid) check("res_data_model", 64'(res_data), 64'(job_sum));
         if (prev_hold) begin
            check("res_valid_held", 64'(res_valid), 64'd1);
            check("res_data_held", 64'(res_data), 64'(prev_data));
         end
         if (s_ready || res_valid || mac_out_en) check("busy_active", 64'(busy), 64'd1);

         pend_acc = s_valid && s_ready;
         pend_a   = s_a;
         pend_b   = s_b;
         if (pend_acc) job_sum = job_sum + s_a * s_b;
         prev_hs   = res_valid && res_ready;
         prev_hold = res_valid && !res_ready;
         prev_data = res_data;
         if (prev_hs) job_sum = '0;
      end
   end

   logic [DATA_W-1:0] va [16];
   logic [DATA_W-1:0] vb [16];

   task automatic wait_idle();
      int i = 0;
      while (busy && i < 32) begin
         @(posedge clk); #1;
         i++;
      end
      check("idle_reached", 64'(busy), 64'd0);
   endtask

   // One job: va/vb hold the pairs, vpat gates s_valid per cycle, poison keeps
   // s_valid high with junk once all pairs are offered.
   task automatic run_job(input string tag, input int n, input logic [7:0] vpat,
                          input bit early_valid, input bit poison, input int ready_delay,
                          input bit poke_start, input int exp_lat, input logic [DATA_W-1:0] exp_res);
      int idx = 0, lat = 0, k = 0, oen_base;
      bit took, got = 1'b0, saw_ready = 1'b0;
      wait_idle();
      oen_base = oen_cnt;
      start    = 1'b1;
      len      = CNT_W'(n);
      s_valid  = early_valid && (n > 0);
      s_a      = va[0];
      s_b      = vb[0];
      while (lat < 64 && !got) begin
         took = s_valid && s_ready;
         @(posedge clk); #1;
         lat++;
         if (took) idx++;
         start = 1'b0;
         len   = '1;
         if (s_ready) saw_ready = 1'b1;
         if (res_valid) begin
            got = 1'b1;
         end else begin
            if (idx < n) begin
               s_valid = vpat[k % 8];
               s_a     = va[idx];
               s_b     = vb[idx];
            end else if (poison) begin
               s_valid = 1'b1;
               s_a     = 16'h1234;
               s_b     = 16'h5678;
            end else begin
               s_valid = 1'b0;
               s_a     = '0;
               s_b     = '0;
            end
            k++;
         end
      end
      s_valid = 1'b0;
      check({tag, "_result_arrived"}, 64'(got), 64'd1);
      check({tag, "_pairs_taken"}, 64'(idx), 64'(n));
      check({tag, "_s_ready_seen"}, 64'(saw_ready), 64'(n > 0));
      if (exp_lat >= 0) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_res_data"}, 64'(res_data), 64'(exp_res));

      for (int i = 0; i < ready_delay; i++) begin
         start = poke_start && (i == 3);
         len   = CNT_W'(3);
         @(posedge clk); #1;
      end
      start = 1'b0;
      check({tag, "_held_valid"}, 64'(res_valid), 64'd1);
      check({tag, "_held_data"}, 64'(res_data), 64'(exp_res));

      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_valid_dropped"}, 64'(res_valid), 64'd0);
      check({tag, "_dump_count"}, 64'(oen_cnt - oen_base), 64'd1);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check({tag, "_idle_after"}, 64'({busy, s_ready, done}), 64'd0);
      end
   endtask

   initial begin
      int oen_base, done_base;
      rst = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0;
      s_a = '0; s_b = '0; res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_out_en", 64'(mac_out_en), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("clear_pulse", 64'(mac_out_en), 64'd1);
      check("clear_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
      check("clear_pulse_end", 64'(mac_out_en), 64'd0);
      @(posedge clk); #1;
      check("clear_to_idle", 64'(busy), 64'd0);

      // 1*2 + 3*4 + 5*6 = 44
      va[0] = 16'd1; vb[0] = 16'd2;
      va[1] = 16'd3; vb[1] = 16'd4;
      va[2] = 16'd5; vb[2] = 16'd6;
      run_job("streamed", 3, 8'hff, 1'b0, 1'b0, 2, 1'b0, 7, 16'd44);
      run_job("toggled", 3, 8'h55, 1'b0, 1'b0, 1, 1'b0, -1, 16'd44);
      run_job("empty", 0, 8'hff, 1'b0, 1'b0, 1, 1'b0, -1, 16'd0);

      // 2*3 + 4*5 = 26, downstream stalls 10 cycles, stray start during hold
      va[0] = 16'd2; vb[0] = 16'd3;
      va[1] = 16'd4; vb[1] = 16'd5;
      run_job("stalled", 2, 8'hff, 1'b0, 1'b0, 10, 1'b1, 6, 16'd26);

      // Abort after two of four pairs; the partial 81+64 must not leak into the next job.
      wait_idle();
      start = 1'b1; len = CNT_W'(4);
      @(posedge clk); #1;
      start = 1'b0;
      s_valid = 1'b1; s_a = 16'd9; s_b = 16'd9;
      @(posedge clk); #1;
      s_a = 16'd8; s_b = 16'd8;
      @(posedge clk); #1;
      oen_base  = oen_cnt;
      done_base = done_cnt;
      rst = 1'b1; s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      wait_idle();
      check("abort_purge_dump", 64'(oen_cnt - oen_base), 64'd1);
      check("abort_no_done", 64'(done_cnt - done_base), 64'd0);
      check("abort_no_result", 64'(res_valid), 64'd0);
      va[0] = 16'd7; vb[0] = 16'd7;
      run_job("after_abort", 1, 8'hff, 1'b0, 1'b0, 1, 1'b0, 5, 16'd49);

      // 0xffff*0xff12 = 0xff1100ee -> 0x00ee per pair, two pairs -> 0x01dc
      va[0] = 16'hffff; vb[0] = 16'hff12;
      va[1] = 16'hffff; vb[1] = 16'hff12;
      run_job("wide", 2, 8'hff, 1'b1, 1'b1, 1, 1'b0, 6, 16'h01dc);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: still running at %0t, required to have finished", $time);
      $fatal(1, "bench timeout");
   end

endmodule
